// File: rtl/popcount_serial_acc.sv
// rtl/popcount_serial_acc.sv - multi-cycle chunked popcount with exact/approximate accumulation and threshold fire bit
module popcount_serial_acc #(
  parameter int N_IN  = 30,
  parameter int CHUNK = 8,
  parameter int DROP  = 1,
  localparam int NCH   = (N_IN + CHUNK - 1) / CHUNK,
  localparam int CNT_W = $clog2(N_IN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_mode_approx,
  input  logic [CNT_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_fire,
  output logic             busy
);

  localparam int PW    = $clog2(CHUNK + 1);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PAD_W = NCH * CHUNK;
  localparam logic [PW-1:0]    KEEP_MASK = ~PW'((1 << DROP) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [PAD_W-1:0] data_q;
  logic [PAD_W-1:0] data_pad;
  logic             approx_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    part;
  logic [PW-1:0]    part_m;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Zero-extend so the last slice reads bits beyond N_IN as 0.
  always_comb begin
    data_pad = '0;
    data_pad[N_IN-1:0] = in_data;
  end

  // The current chunk always sits in the low CHUNK bits; data_q shifts down each cycle.
  always_comb begin
    part = '0;
    for (int i = 0; i < CHUNK; i++) begin
      part = part + PW'(data_q[i]);
    end
    part_m   = approx_q ? (part & KEEP_MASK) : part;
    acc_next = acc + CNT_W'(part_m);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      approx_q  <= 1'b0;
      thr_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
      out_fire  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= data_pad;
            approx_q <= in_mode_approx;
            thr_q    <= in_thresh;
            acc      <= '0;
            idx      <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc    <= acc_next;
          data_q <= data_q >> CHUNK;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_count <= acc_next;
            out_fire  <= (acc_next >= thr_q);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_serial_acc.sv
// tb/tb_popcount_serial_acc.sv - directed and model-based bench for popcount_serial_acc
module tb_popcount_serial_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic        in_mode_approx;
  logic [4:0]  in_thresh;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        out_fire;
  logic        busy;

  int n_checks;
  int n_pass;

  popcount_serial_acc #(.N_IN(30), .CHUNK(8), .DROP(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode_approx(in_mode_approx),
    .in_thresh(in_thresh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_fire(out_fire),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Independent reference: walk the 30-bit vector in 8-bit groups, clear bit 0 of each group count in approx mode.
  function automatic int model_count(input logic [29:0] d, input logic approx);
    int total = 0;
    for (int c = 0; c < 4; c++) begin
      int p = 0;
      for (int b = 0; b < 8; b++) begin
        if (c * 8 + b < 30 && d[c * 8 + b]) p++;
      end
      if (approx) p = p & ~1;
      total += p;
    end
    return total;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one vector, optionally churns inputs during ACCUM and holds off out_ready, then checks the result.
  task automatic run_vec(input string tag, input logic [29:0] d, input logic approx, input logic [4:0] thr,
                         input int exp_cnt, input int exp_fire, input int hold, input bit churn);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    in_valid       = 1'b1;
    in_data        = d;
    in_mode_approx = approx;
    in_thresh      = thr;
    tick();
    in_valid = 1'b0;
    if (churn) begin
      in_valid       = 1'b1;
      in_data        = ~d;
      in_mode_approx = ~approx;
      in_thresh      = 5'd31 - thr;
      out_ready      = 1'b1;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_lat"}, lat, 4);
    check({tag, "_cnt"}, int'(out_count), exp_cnt);
    check({tag, "_fire"}, int'(out_fire), exp_fire);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_cnt"}, int'(out_count), exp_cnt);
      check({tag, "_hold_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, int'(out_valid), 0);
    check({tag, "_post_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [29:0] rd;
    logic        rm;
    logic [4:0]  rt;
    int          rc;
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    in_mode_approx = 1'b0;
    in_thresh      = '0;
    out_ready      = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count", int'(out_count), 0);
    check("rst_fire", int'(out_fire), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    run_vec("ones_exact", 30'h3FFFFFFF, 1'b0, 5'd16, 30, 1, 0, 0);
    run_vec("ones_approx", 30'h3FFFFFFF, 1'b1, 5'd31, 30, 0, 0, 0);
    run_vec("v107_approx", 30'h00000107, 1'b1, 5'd0, 2, 1, 0, 0);
    run_vec("v107_exact", 30'h00000107, 1'b0, 5'd5, 4, 0, 0, 0);
    run_vec("thr15", 30'h00007FFF, 1'b0, 5'd15, 15, 1, 0, 0);
    run_vec("thr16", 30'h00007FFF, 1'b0, 5'd16, 15, 0, 0, 0);
    run_vec("zero_thr0", 30'h00000000, 1'b0, 5'd0, 0, 1, 0, 0);
    run_vec("backpressure", 30'h2AAAAAAA, 1'b0, 5'd15, 15, 1, 10, 0);
    run_vec("churn", 30'h0F0F0F0F, 1'b0, 5'd16, 16, 1, 0, 1);

    // Reset while ACCUM holds idx=2.
    in_valid  = 1'b1;
    in_data   = 30'h3FFFFFFF;
    in_thresh = 5'd1;
    in_mode_approx = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(out_count), 0);
    check("midrst_fire", int'(out_fire), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("postrst_no_valid", int'(out_valid), 0);
    end
    run_vec("after_rst", 30'h00FF00F0, 1'b1, 5'd12, 12, 1, 0, 0);

    for (int k = 0; k < 20; k++) begin
      rd = 30'($urandom());
      rm = 1'($urandom_range(0, 1));
      rt = 5'($urandom_range(0, 31));
      rc = model_count(rd, rm);
      run_vec("rand", rd, rm, rt, rc, (rc >= int'(rt)) ? 1 : 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
